// File: rtl/font_rom_arbiter.sv
// Font ROM arbiter: port 0 (video fetch) has priority, ports 1..N_REQ-1
// share the ROM round-robin; read data returns ROM_LAT+1 cycles after gnt.
// Ports: clk, rst_n (sync, active-low), req/addr per port, gnt/rvalid
// one-hot, rdata shared, rom_clk/rom_addr/rom_q to the ROM.
// Optional macro FONT_ROM_ARB_STARVE_GUARD_EN: after MAX_STREAK port-0
// grants with others pending, one grant is forced to the round-robin winner.
module font_rom_arbiter #(
  parameter int ADDR_SIZE  = 7,
  parameter int FNT_W      = 4,
  parameter int N_REQ      = 3,
  parameter int ROM_LAT    = 2,
  parameter int MAX_STREAK = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*ADDR_SIZE-1:0] addr,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           rvalid,
  output logic [FNT_W-1:0]           rdata,
  output logic                       rom_clk,
  output logic [ADDR_SIZE-1:0]       rom_addr,
  input  logic [FNT_W-1:0]           rom_q
);

  localparam int PW = $clog2(N_REQ);

  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        ptr_nxt;
  logic [N_REQ-1:0]     gnt_nxt;
  logic [ADDR_SIZE-1:0] addr_nxt;
  logic [N_REQ-1:0]     rr_win;
  logic                 rr_hit;
  logic [PW-1:0]        rr_idx;
  logic                 others;
  logic                 force_rr;
  logic [N_REQ-1:0]     pv [ROM_LAT];

  assign rom_clk = clk;
  assign others  = |req[N_REQ-1:1];

  // Port visited at offset i of the scan starting at rr_ptr, skipping 0.
  function automatic int rr_port(input int p, input int i);
    return ((p - 1 + i) % (N_REQ - 1)) + 1;
  endfunction

  function automatic logic [PW-1:0] wrap_next(input int k);
    return (k >= N_REQ - 1) ? PW'(1) : PW'(k + 1);
  endfunction

  always_comb begin
    rr_win = '0;
    rr_hit = 1'b0;
    rr_idx = rr_ptr;
    for (int i = 0; i < N_REQ - 1; i++) begin
      if (!rr_hit && req[rr_port(int'(rr_ptr), i)]) begin
        rr_hit = 1'b1;
        rr_win[rr_port(int'(rr_ptr), i)] = 1'b1;
        rr_idx = PW'(rr_port(int'(rr_ptr), i));
      end
    end
  end

`ifdef FONT_ROM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(MAX_STREAK + 1);

  logic [SW-1:0] streak;

  assign force_rr = (streak == SW'(MAX_STREAK)) && others;

  always_ff @(posedge clk) begin
    if (!rst_n)
      streak <= '0;
    else if (gnt_nxt[0] && others)
      streak <= streak + SW'(1);
    else
      streak <= '0;
  end
`else
  assign force_rr = 1'b0;
`endif

  always_comb begin
    gnt_nxt  = '0;
    addr_nxt = rom_addr;
    ptr_nxt  = rr_ptr;
    if (req[0] && !force_rr) begin
      gnt_nxt[0] = 1'b1;
      addr_nxt   = addr[0 +: ADDR_SIZE];
    end else if (rr_hit) begin
      gnt_nxt  = rr_win;
      addr_nxt = addr[int'(rr_idx)*ADDR_SIZE +: ADDR_SIZE];
      ptr_nxt  = wrap_next(int'(rr_idx));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt      <= '0;
      rom_addr <= '0;
      rr_ptr   <= PW'(1);
      rvalid   <= '0;
      rdata    <= '0;
      for (int i = 0; i < ROM_LAT; i++)
        pv[i] <= '0;
    end else begin
      gnt      <= gnt_nxt;
      rom_addr <= addr_nxt;
      rr_ptr   <= ptr_nxt;
      pv[0]    <= gnt;
      for (int i = 1; i < ROM_LAT; i++)
        pv[i] <= pv[i-1];
      rvalid <= pv[ROM_LAT-1];
      if (|pv[ROM_LAT-1])
        rdata <= rom_q;
    end
  end

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Testbench for font_rom_arbiter: directed table, corner sequences and
// random traffic checked against a queue-based reference model.
module tb_font_rom_arbiter;

  localparam int AW = 7;
  localparam int FW = 4;
  localparam int N  = 3;
  localparam int L  = 2;
  localparam int MS = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*AW-1:0] addr;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [FW-1:0]   rdata;
  logic            rom_clk;
  logic [AW-1:0]   rom_addr;
  logic [FW-1:0]   rom_q;

  font_rom_arbiter #(
    .ADDR_SIZE(AW), .FNT_W(FW), .N_REQ(N),
    .ROM_LAT(L), .MAX_STREAK(MS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .rom_clk(rom_clk), .rom_addr(rom_addr), .rom_q(rom_q)
  );

  always #5 clk = ~clk;

  logic [FW-1:0] rom [128];
  logic [FW-1:0] rp [L];

  always @(posedge rom_clk) begin
    rp[0] <= rom[rom_addr];
    for (int i = 1; i < L; i++)
      rp[i] <= rp[i-1];
  end
  assign rom_q = rp[L-1];

  typedef struct {
    int due;
    int port;
    int a;
  } rd_t;

  rd_t           q[$];
  int            rr;
  int            streak;
  int            cyc;
  logic [N-1:0]  e_gnt;
  logic [N-1:0]  e_rv;
  logic [FW-1:0] e_rd;
  logic [AW-1:0] e_addr;
  int            errs = 0;
  int            checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference: priority/round-robin choice on integers, reads queued
  // with their due cycle.
  task automatic model_step();
    int  w;
    bit  oth;
    bit  frc;
    cyc++;
    if (!rst_n) begin
      e_gnt = '0; e_rv = '0; e_rd = '0; e_addr = '0;
      rr = 1; streak = 0; q.delete();
    end else begin
      w   = -1;
      oth = |req[N-1:1];
      frc = 1'b0;
`ifdef FONT_ROM_ARB_STARVE_GUARD_EN
      frc = (streak == MS) && oth;
`endif
      if (req[0] && !frc)
        w = 0;
      else
        for (int i = 0; i < N - 1; i++)
          if (w < 0 && req[((rr - 1 + i) % (N - 1)) + 1])
            w = ((rr - 1 + i) % (N - 1)) + 1;
      streak = (w == 0 && oth) ? streak + 1 : 0;
      if (w >= 1) rr = (w == N - 1) ? 1 : w + 1;
      e_gnt = '0;
      if (w >= 0) begin
        e_gnt[w] = 1'b1;
        e_addr = addr[w*AW +: AW];
        q.push_back('{cyc + L + 1, w, int'(e_addr)});
      end
      e_rv = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        e_rv[q[0].port] = 1'b1;
        e_rd = rom[q[0].a];
        void'(q.pop_front());
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("rvalid", 32'(rvalid), 32'(e_rv));
    chk("rdata", 32'(rdata), 32'(e_rd));
    chk("rom_addr", 32'(rom_addr), 32'(e_addr));
  endtask

  typedef struct {
    logic [N-1:0]  req;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [N-1:0]  gnt;
    logic [AW-1:0] ra;
  } vec_t;

  vec_t tv [11];

  initial begin
    int npulse;
    tv[0]  = '{3'b010, 7'h00, 7'h25, 7'h00, 3'b010, 7'h25};
    tv[1]  = '{3'b000, 7'h00, 7'h25, 7'h00, 3'b000, 7'h25};
    tv[2]  = '{3'b110, 7'h00, 7'h11, 7'h22, 3'b100, 7'h22};
    tv[3]  = '{3'b110, 7'h00, 7'h11, 7'h22, 3'b010, 7'h11};
    tv[4]  = '{3'b110, 7'h00, 7'h11, 7'h22, 3'b100, 7'h22};
    tv[5]  = '{3'b111, 7'h03, 7'h11, 7'h22, 3'b001, 7'h03};
    tv[6]  = '{3'b111, 7'h03, 7'h11, 7'h22, 3'b001, 7'h03};
    tv[7]  = '{3'b111, 7'h03, 7'h11, 7'h22, 3'b001, 7'h03};
    tv[8]  = '{3'b111, 7'h03, 7'h11, 7'h22, 3'b001, 7'h03};
    tv[9]  = '{3'b100, 7'h03, 7'h11, 7'h22, 3'b100, 7'h22};
    tv[10] = '{3'b010, 7'h03, 7'h7f, 7'h22, 3'b010, 7'h7f};

    for (int i = 0; i < 128; i++)
      rom[i] = FW'($urandom);
    cyc = 0;
    rst_n = 1'b0;
    req = '0;
    addr = '0;
    step();
    step();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);

    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      req  = tv[i].req;
      addr = {tv[i].a2, tv[i].a1, tv[i].a0};
      step();
      chk("tv_gnt", 32'(gnt), 32'(tv[i].gnt));
      chk("tv_rom_addr", 32'(rom_addr), 32'(tv[i].ra));
      if (i == 3) begin
        chk("single_rvalid", 32'(rvalid), 32'b010);
        chk("single_rdata", 32'(rdata), 32'(rom[7'h25]));
      end
    end

    // Reset with a port-2 read in flight.
    req = 3'b100;
    addr = {7'h33, 7'h00, 7'h00};
    step();
    chk("mid_gnt", 32'(gnt), 32'b100);
    rst_n = 1'b0;
    req = '0;
    step();
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_rvalid", 32'(rvalid), 32'h0);
    chk("mid_rst_rdata", 32'(rdata), 32'h0);
    chk("mid_rst_addr", 32'(rom_addr), 32'h0);
    rst_n = 1'b1;
    step();
    step();
    chk("mid_no_rvalid", 32'(rvalid), 32'h0);
    step();

    // Port 0 streaming 0..15.
    npulse = 0;
    for (int a = 0; a < 16 + L + 2; a++) begin
      req  = (a < 16) ? 3'b001 : 3'b000;
      addr = {7'h00, 7'h00, 7'(a)};
      step();
      if (rvalid[0]) begin
        chk("stream_rdata", 32'(rdata), 32'(rom[npulse]));
        npulse++;
      end
    end
    chk("stream_count", 32'(npulse), 32'd16);

`ifdef FONT_ROM_ARB_STARVE_GUARD_EN
    rst_n = 1'b0;
    req = '0;
    step();
    rst_n = 1'b1;
    req = 3'b011;
    addr = {7'h00, 7'h02, 7'h01};
    for (int i = 0; i < MS + 2; i++) begin
      step();
      chk("guard_gnt", 32'(gnt), (i == MS) ? 32'b010 : 32'b001);
    end
    req = '0;
    for (int i = 0; i < L + 2; i++)
      step();
`endif

    // Random traffic with the hold-until-granted rule.
    for (int c = 0; c < 2000; c++) begin
      rst_n = ($urandom_range(199) != 0);
      for (int k = 0; k < N; k++) begin
        if (!(req[k] && !e_gnt[k])) begin
          req[k] = ($urandom_range(99) < ((k == 0) ? 30 : 50));
          addr[k*AW +: AW] = AW'($urandom);
        end
      end
      step();
    end
    rst_n = 1'b1;
    req = '0;
    for (int i = 0; i < L + 3; i++)
      step();
    chk("drain_empty", 32'(q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
